// File: rtl/bike_syndrome_weight.sv
// Streams the syndrome RAM word by word and accumulates its Hamming weight `s`.
// Optional BIKE_SW_POPCNT_PIPE_EN splits the popcount into two registered stages.
module bike_syndrome_weight #(
    parameter int R_BITS   = 12323,
    parameter int B_WIDTH  = 32,
    parameter int WORDS    = (R_BITS + B_WIDTH - 1) / B_WIDTH,
    parameter int LOGRBITS = $clog2(R_BITS + 1)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    output logic                       busy,
    output logic                       rd_en,
    output logic [$clog2(WORDS)-1:0]   rd_addr,
    input  logic [B_WIDTH-1:0]         rd_data,
    output logic [LOGRBITS-1:0]        s,
    output logic                       done,
    output logic                       zero
);
    localparam int AW        = $clog2(WORDS);
    localparam int PCW       = $clog2(B_WIDTH + 1);
    localparam int LAST_BITS = R_BITS - (WORDS - 1) * B_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
`ifdef BIKE_SW_POPCNT_PIPE_EN
    localparam logic [1:0] DRAIN_LAST = 2'd2;
`else
    localparam logic [1:0] DRAIN_LAST = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       addr_reg, addr_next;
    logic [1:0]          drain_reg, drain_next;
    logic                valid_reg, last_reg;
    logic                pc_valid_reg;
    logic [PCW-1:0]      pc_reg;
    logic [LOGRBITS-1:0] acc_reg;
    logic                zero_reg;
    logic [B_WIDTH-1:0]  mask;
    logic [B_WIDTH-1:0]  masked;
    logic                start_accept;

    // Padding bits above R_BITS in the final word are forced to zero.
    generate
        for (genvar gi = 0; gi < B_WIDTH; gi++) begin : g_mask
            assign mask[gi] = (gi < LAST_BITS);
        end
    endgenerate

    assign masked       = last_reg ? (rd_data & mask) : rd_data;
    assign start_accept = (state_reg == IDLE) && start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            drain_reg <= drain_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        drain_next = drain_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                    addr_next  = '0;
                end
            end
            READ: begin
                if (addr_reg == LAST_ADDR) begin
                    state_next = DRAIN;
                    addr_next  = '0;
                    drain_next = '0;
                end else begin
                    addr_next = addr_reg + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = DONE;
                end else begin
                    drain_next = drain_reg + 2'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            valid_reg <= rd_en;
            last_reg  <= rd_en && (addr_reg == LAST_ADDR);
        end
    end

`ifdef BIKE_SW_POPCNT_PIPE_EN
    localparam int LO_W = B_WIDTH / 2;
    localparam int HI_W = B_WIDTH - LO_W;

    logic [PCW-1:0] half_lo, half_hi;
    logic [PCW-1:0] half_lo_reg, half_hi_reg;
    logic           half_valid_reg;

    always_comb begin
        half_lo = '0;
        half_hi = '0;
        for (int i = 0; i < LO_W; i++) half_lo = half_lo + PCW'(masked[i]);
        for (int i = 0; i < HI_W; i++) half_hi = half_hi + PCW'(masked[LO_W + i]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            half_lo_reg    <= '0;
            half_hi_reg    <= '0;
            half_valid_reg <= 1'b0;
            pc_reg         <= '0;
            pc_valid_reg   <= 1'b0;
        end else begin
            half_lo_reg    <= half_lo;
            half_hi_reg    <= half_hi;
            half_valid_reg <= valid_reg;
            pc_reg         <= half_lo_reg + half_hi_reg;
            pc_valid_reg   <= half_valid_reg;
        end
    end
`else
    logic [PCW-1:0] pc_full;

    always_comb begin
        pc_full = '0;
        for (int i = 0; i < B_WIDTH; i++) pc_full = pc_full + PCW'(masked[i]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_reg       <= '0;
            pc_valid_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_full;
            pc_valid_reg <= valid_reg;
        end
    end
`endif

    // The pipeline is always empty in IDLE, so clearing and adding never collide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_reg  <= '0;
            zero_reg <= 1'b0;
        end else begin
            if (start_accept) begin
                acc_reg <= '0;
            end else if (pc_valid_reg) begin
                acc_reg <= acc_reg + LOGRBITS'(pc_reg);
            end
            if (start_accept) begin
                zero_reg <= 1'b0;
            end else if (state_reg == DONE) begin
                zero_reg <= (acc_reg == '0);
            end
        end
    end

    assign busy    = (state_reg != IDLE);
    assign rd_en   = (state_reg == READ);
    assign rd_addr = addr_reg;
    assign done    = (state_reg == DONE);
    assign s       = acc_reg;
    // The final sum lands on the same edge that enters DONE, so zero is decoded live there.
    assign zero    = (state_reg == DONE) ? (acc_reg == '0) : zero_reg;

endmodule

// File: tb/tb_bike_syndrome_weight.sv
// Scoreboarded, table-driven bench for bike_syndrome_weight with a behavioural syndrome RAM.
`timescale 1ns/1ps
module tb_bike_syndrome_weight;
    localparam int R_BITS   = 12323;
    localparam int B_WIDTH  = 32;
    localparam int WORDS    = 386;
    localparam int LOGRBITS = 14;
    localparam int AW       = 9;
`ifdef BIKE_SW_POPCNT_PIPE_EN
    localparam int LAT = 389;
`else
    localparam int LAT = 388;
`endif

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                start = 1'b0;
    logic                busy, rd_en, done, zero;
    logic [AW-1:0]       rd_addr;
    logic [B_WIDTH-1:0]  rd_data = '0;
    logic [LOGRBITS-1:0] s;
    logic [B_WIDTH-1:0]  mem [0:WORDS-1];

    bike_syndrome_weight dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .busy    (busy),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .s       (s),
        .done    (done),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int exp_s;
        bit exp_zero;
        int start_cyc;
        int rd_base;
    } exp_t;

    typedef struct {
        int s;
        bit zero;
        int cyc;
        int rd_total;
        bit busy;
    } obs_t;

    typedef struct {
        int kind;
        int exp_s;
        bit exp_zero;
        bit extra;
    } vec_t;

    exp_t sb[$];
    obs_t obs[$];
    int   rd_total = 0;
    int   addr_bad = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Monitor samples 1 ns after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_en) begin
                rd_total = rd_total + 1;
                if (rd_addr >= AW'(WORDS)) addr_bad = addr_bad + 1;
            end
            if (done) obs.push_back('{int'(s), zero, cyc, rd_total, busy});
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int kind);
        int n;
        int b;
        for (int w = 0; w < WORDS; w++)
            mem[w] = (kind == 1) ? 32'hFFFF_FFFF : (kind == 4) ? 32'h5555_5555 : 32'h0;
        case (kind)
            2: mem[WORDS-1] = 32'hFFFF_FFFC;
            3: begin
                n = 0;
                while (n < 137) begin
                    b = int'($urandom_range(R_BITS - 1, 0));
                    if (!mem[b / 32][b % 32]) begin
                        mem[b / 32][b % 32] = 1'b1;
                        n++;
                    end
                end
                mem[WORDS-1] = mem[WORDS-1] | (32'hFFFF_FFF8 & $urandom());
            end
            5: mem[WORDS-1] = 32'hFFFF_FFF8;
            6: begin
                mem[0]       = 32'hFFFF_FFFF;
                mem[WORDS-1] = 32'h0000_0007;
            end
            default: ;
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic begin_op(input int es, input bit ez);
        exp_t e;
        start = 1'b1;
        e = '{es, ez, cyc + 1, rd_total};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("s_cleared_on_start", s, 0);
        chk("zero_cleared_on_start", zero, 0);
        chk("rd_en_first_cycle", rd_en, 1);
        chk("rd_addr_first", rd_addr, 0);
    endtask

    // Waits for completion, compares against the scoreboard, returns at the negedge after done.
    task automatic finish_op();
        exp_t e;
        obs_t o;
        int   t;
        t = 0;
        while (obs.size() == 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        e = sb.pop_front();
        if (obs.size() == 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            o = obs.pop_front();
            $display("op: s=%0d zero=%0d latency=%0d rd_cycles=%0d (expect s=%0d zero=%0d)",
                     o.s, o.zero, o.cyc - e.start_cyc, o.rd_total - e.rd_base, e.exp_s, e.exp_zero);
            chk("s_at_done", o.s, e.exp_s);
            chk("zero_at_done", o.zero, e.exp_zero);
            chk("done_latency", o.cyc - e.start_cyc, LAT);
            chk("rd_en_cycles", o.rd_total - e.rd_base, WORDS);
            chk("busy_at_done", o.busy, 1);
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("done_single_pulse", done, 0);
            chk("s_held", s, e.exp_s);
            chk("zero_held", zero, e.exp_zero);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 0,     1'b1, 1'b0};
        vecs[1] = '{1, 12323, 1'b0, 1'b0};
        vecs[2] = '{2, 1,     1'b0, 1'b0};
        vecs[3] = '{3, 137,   1'b0, 1'b1};
        vecs[4] = '{4, 6162,  1'b0, 1'b0};
        vecs[5] = '{5, 0,     1'b1, 1'b0};
        vecs[6] = '{6, 35,    1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_s", s, 0);
        chk("reset_done", done, 0);
        chk("reset_zero", zero, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Consecutive operations start in the cycle right after the previous done.
        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].kind);
            begin_op(vecs[v].exp_s, vecs[v].exp_zero);
            if (vecs[v].extra) begin
                repeat (50) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("busy_during_ignored_start", busy, 1);
            end
            finish_op();
        end

        // Reset asserted mid-count: everything clears and no done follows.
        fill(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_rd_en", rd_en, 0);
        chk("midreset_rd_addr", rd_addr, 0);
        chk("midreset_s", s, 0);
        chk("midreset_done", done, 0);
        chk("midreset_zero", zero, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (450) @(negedge clk);
        chk("no_done_after_reset", obs.size(), 0);
        obs.delete();

        begin_op(137, 1'b0);
        finish_op();

        chk("rd_addr_in_range", addr_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bike_syndrome_weight.md
# bike_syndrome_weight

Streams the syndrome out of its block RAM word by word, counts its Hamming weight and presents the weight `s` to the decoder's threshold computation. It sits between the syndrome memory and the threshold unit in each decoder iteration. It is the producer of the `s` operand that the threshold unit consumes, and it raises `zero` so the decoder can stop as soon as the syndrome vanishes.

## Interface
Parameters:
- `R_BITS`, 12323: syndrome length in bits (BIKE L1).
- `B_WIDTH`, 32: RAM word width in bits.
- `WORDS`, ceil(R_BITS/B_WIDTH): number of RAM words read per count.
- `LOGRBITS`, $clog2(R_BITS+1): width of `s`.

Ports:
- `clk` input, 1: single clock; all logic is rising-edge.
- `resetn` input, 1: reset, asynchronous, active-low.
- `start` input, 1: single-cycle request to begin a count.
- `busy` output, 1: high from the cycle after `start` is accepted until `done`.
- `rd_en` output, 1: syndrome RAM read enable.
- `rd_addr` output, $clog2(WORDS): syndrome RAM word address.
- `rd_data` input, B_WIDTH: RAM read data, valid 1 cycle after `rd_en`.
- `s` output, LOGRBITS: syndrome weight; held stable between `done` and the next accepted `start`.
- `done` output, 1: one-cycle pulse; `s` is valid from this cycle on.
- `zero` output, 1: high with `done` and held afterwards when `s == 0`.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on `start == 1`, clear the accumulator and go to READ. `start` is ignored in every other state.
  - READ: `rd_en = 1`, with `rd_addr` counting 0 .. WORDS-1, one address per cycle. After address WORDS-1 is issued, go to DRAIN.
  - DRAIN: wait for the in-flight data and popcount stages to empty (2 cycles, 3 with the macro).
  - DONE: pulse `done`, register `zero`, return to IDLE.
- Datapath:
  - Read-valid flag: `rd_en` delayed by 1 cycle.
  - Mask: the word read from address WORDS-1 is ANDed with a mask that keeps only its low `R_BITS - (WORDS-1)*B_WIDTH` bits. The bits above that are padding and never count. No mask is applied when R_BITS is a multiple of B_WIDTH.
  - Popcount: population count of the masked word, registered. The result width is $clog2(B_WIDTH+1).
  - Accumulator: LOGRBITS bits, zero-extended add of each registered popcount. It cannot overflow because the maximum value is R_BITS.
- `s` is the accumulator output. It changes only while `busy` is high and after `done` it holds its value until the next accepted `start`.
- The block never reads a RAM address ≥ WORDS.

## Timing
- Reset values: `busy=0`, `rd_en=0`, `rd_addr=0`, `s=0`, `done=0`, `zero=0`; FSM in IDLE.
- `start` sampled high at edge k:
  - `rd_en` is high for cycles k..k+WORDS-1.
  - `done` pulses in cycle k+WORDS+2 (k+WORDS+3 with the macro).
  - `busy` is high from cycle k until `done`, inclusive.
- Back-to-back operation: `start` may be asserted in the cycle right after `done`. `s` keeps its old value until that `start` is accepted, then clears.
- `start` is ignored while `busy` is high; the in-progress count is not disturbed.
- Reset asserted mid-count: all outputs go to their reset values immediately and no `done` is produced. The RAM content is not affected.
- Throughput: one word per cycle with no bubbles.

## Configuration
- `BIKE_SW_POPCNT_PIPE_EN`
  - Defined: the popcount is split into two registered halves (per-half counts, then their sum). This adds 1 cycle to DRAIN and to the total latency. It is intended for large B_WIDTH at high clock frequency.
  - Undefined: single-stage popcount and the latencies given above.
  - Functional results are identical in both builds; only the cycle of `done` moves.

## Test plan
- All-zero syndrome, R_BITS=12323, B_WIDTH=32 -> `done` at start+388, `s=0`, `zero=1`.
- All-ones RAM, including the padding bits of word 385 -> `s=12323` (only 3 bits of the last word counted), `zero=0`.
- A single 1 at bit 12322, plus padding bits 3..31 of the last word set to 1 -> `s=1`.
- Random syndrome with weight 137 -> `s=137`. A second `start` issued during the count is ignored; `rd_en` is high for exactly 386 cycles.
- `resetn` pulsed low at cycle start+100 -> all outputs return to 0 and no `done` appears. A fresh `start` after reset then completes with the correct `s`.
- Build with `BIKE_SW_POPCNT_PIPE_EN` and repeat the weight-137 case -> `s=137` with `done` at start+389.
